// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter for one shared variable-latency memory bus; optional ARB_ROUND_ROBIN_EN
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t            state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic              bus_req_n, bus_we_n;
   logic [ADDR_W-1:0] bus_addr_n;
   logic [DATA_W-1:0] bus_wdata_n;
   logic              if_ack_n, mem_ack_n;
   logic [DATA_W-1:0] if_rdata_n, mem_rdata_n;
   logic              timeout_err_n;
   logic              if_ok, mem_ok, grant_if, grant_mem;
   logic              complete;
   logic [DATA_W-1:0] cap_data;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = MEM won the last contended grant, 0 = IF
   logic last_grant, last_grant_n;
`endif

   // A port being acked this cycle still shows req high; mask it so it is not re-granted
   always_comb begin
      if_ok  = if_req & ~if_ack;
      mem_ok = mem_req & ~mem_ack;
`ifdef ARB_ROUND_ROBIN_EN
      grant_mem    = mem_ok & (~if_ok | ~last_grant);
      grant_if     = if_ok & ~grant_mem;
      last_grant_n = last_grant;
      if (state == IDLE && if_ok && mem_ok) begin
         last_grant_n = grant_mem;
      end
`else
      grant_mem = mem_ok;
      grant_if  = if_ok & ~mem_ok;
`endif
   end

   // Next-state, bus register and completion logic
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      bus_req_n     = bus_req;
      bus_we_n      = bus_we;
      bus_addr_n    = bus_addr;
      bus_wdata_n   = bus_wdata;
      if_ack_n      = 1'b0;
      mem_ack_n     = 1'b0;
      if_rdata_n    = if_rdata;
      mem_rdata_n   = mem_rdata;
      timeout_err_n = timeout_err;
      complete      = 1'b0;
      cap_data      = '0;

      case (state)
         IDLE: begin
            if (grant_mem) begin
               state_n     = BUSY_MEM;
               bus_req_n   = 1'b1;
               bus_we_n    = mem_we;
               bus_addr_n  = mem_addr;
               bus_wdata_n = mem_wdata;
               cnt_n       = '0;
            end else if (grant_if) begin
               state_n     = BUSY_IF;
               bus_req_n   = 1'b1;
               bus_we_n    = 1'b0;
               bus_addr_n  = if_addr;
               bus_wdata_n = '0;
               cnt_n       = '0;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            if (bus_ready) begin
               complete = 1'b1;
               cap_data = bus_we ? '0 : bus_rdata;
            end else if (cnt == TIMEOUT_CNT) begin
               complete      = 1'b1;
               timeout_err_n = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (complete) begin
         state_n   = IDLE;
         bus_req_n = 1'b0;
         bus_we_n  = 1'b0;
         cnt_n     = '0;
         if (state == BUSY_MEM) begin
            mem_ack_n   = 1'b1;
            mem_rdata_n = cap_data;
         end else begin
            if_ack_n   = 1'b1;
            if_rdata_n = cap_data;
         end
      end
   end

   // State and registered outputs; reset discards any in-flight access
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         if_ack      <= 1'b0;
         mem_ack     <= 1'b0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bus_req     <= bus_req_n;
         bus_we      <= bus_we_n;
         bus_addr    <= bus_addr_n;
         bus_wdata   <= bus_wdata_n;
         if_ack      <= if_ack_n;
         mem_ack     <= mem_ack_n;
         if_rdata    <= if_rdata_n;
         mem_rdata   <= mem_rdata_n;
         timeout_err <= timeout_err_n;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Reset to IF so MEM wins the first contended grant
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b0;
      end else begin
         last_grant <= last_grant_n;
      end
   end
`endif

   // Stall while any request has not yet been acknowledged
   assign stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, mem_req, mem_we, bus_ready;
   logic [AW-1:0] if_addr, mem_addr;
   logic [DW-1:0] mem_wdata, bus_rdata;
   logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
   logic [AW-1:0] bus_addr;
   logic          if_ack, mem_ack, stall, bus_req, bus_we, timeout_err;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] if_exp[$];
   logic [31:0] mem_exp[$];
   logic [64:0] acc_log[$];
   logic [31:0] bus_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];

   bit          bus_hang = 1'b0;
   int          fixed_wait = -1;
   bit          ovr_en = 1'b0;
   logic [31:0] ovr_data = '0;
   int          n_acc = 0, n_if_ack = 0, n_mem_ack = 0;
   int          cur_cycles = 0, last_bus_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Bus-side memory: answers each access after a chosen number of wait cycles
   initial begin
      int  wait_left;
      bit  active;
      bus_ready = 1'b0;
      bus_rdata = '0;
      active    = 1'b0;
      wait_left = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus_ready) begin
            bus_ready = 1'b0;
            bus_rdata = '0;
            active    = 1'b0;
         end else if (!bus_req) begin
            active = 1'b0;
         end else if (!bus_hang) begin
            if (!active) begin
               active    = 1'b1;
               wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
               bus_ready = 1'b1;
               if (bus_we) begin
                  bus_mem[bus_addr] = bus_wdata;
                  bus_rdata = $urandom;
               end else begin
                  bus_rdata = ovr_en ? ovr_data : bus_rd(bus_addr);
               end
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: pops expected responses on each ack and watches the bus
   initial begin
      logic          p_bus_req = 1'b0, p_bus_we = 1'b0, p_if_ack = 1'b0, p_mem_ack = 1'b0;
      logic [AW-1:0] p_addr = '0;
      logic [DW-1:0] p_wdata = '0;
      forever begin
         @(negedge clk);
         chk1("stall", stall, (if_req & ~if_ack) | (mem_req & ~mem_ack));
         if (bus_req && !p_bus_req) begin
            acc_log.push_back({bus_we, bus_addr, bus_wdata});
            n_acc++;
            cur_cycles = 0;
         end
         if (bus_req && p_bus_req) begin
            chk("bus_addr_hold", bus_addr, p_addr);
            chk1("bus_we_hold", bus_we, p_bus_we);
            chk("bus_wdata_hold", bus_wdata, p_wdata);
         end
         if (bus_req) cur_cycles++;
         if (!bus_req && p_bus_req) last_bus_cycles = cur_cycles;
         if (if_ack) begin
            n_if_ack++;
            chk1("if_ack_width", p_if_ack, 1'b0);
            if (if_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL if_ack_unexpected: got ack with rdata 0x%0h expected no ack", if_rdata);
            end else begin
               chk("if_rdata", if_rdata, if_exp.pop_front());
            end
         end
         if (mem_ack) begin
            n_mem_ack++;
            chk1("mem_ack_width", p_mem_ack, 1'b0);
            if (mem_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL mem_ack_unexpected: got ack with rdata 0x%0h expected no ack", mem_rdata);
            end else begin
               chk("mem_rdata", mem_rdata, mem_exp.pop_front());
            end
         end
         p_bus_req = bus_req;
         p_bus_we  = bus_we;
         p_addr    = bus_addr;
         p_wdata   = bus_wdata;
         p_if_ack  = if_ack;
         p_mem_ack = mem_ack;
      end
   end

   task automatic if_access(input logic [31:0] a, input logic [31:0] e);
      bit got;
      @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = a;
      if_exp.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (if_ack) got = 1'b1;
      end
      chk1("if_ack_seen", got, 1'b1);
      @(posedge clk);
      #1;
      if_req  = 1'b0;
      if_addr = $urandom;
   endtask

   task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] d);
      bit got;
      @(posedge clk);
      #1;
      mem_req   = 1'b1;
      mem_we    = we;
      mem_addr  = a;
      mem_wdata = d;
      if (we) begin
         ref_mem[a] = d;
         mem_exp.push_back(32'h0);
      end else begin
         mem_exp.push_back(ref_rd(a));
      end
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (mem_ack) got = 1'b1;
      end
      chk1("mem_ack_seen", got, 1'b1);
      @(posedge clk);
      #1;
      mem_req   = 1'b0;
      mem_we    = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic check_all_zero();
      chk1("rst_bus_req", bus_req, 1'b0);
      chk1("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_mem_ack", mem_ack, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_timeout_err", timeout_err, 1'b0);
   endtask

   task automatic contention_pair(input logic [31:0] ia, input logic [31:0] ma, input bit if_first);
      logic [64:0] e0, e1;
      acc_log.delete();
      fork
         if_access(ia, init_val(ia));
         mem_access(1'b0, ma, 32'h0);
      join
      settle();
      chk("cont_access_count", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         e0 = acc_log[0];
         e1 = acc_log[1];
         chk("cont_first_addr", e0[63:32], if_first ? ia : ma);
         chk("cont_second_addr", e1[63:32], if_first ? ma : ia);
      end
   endtask

   initial begin
      int          n0, a0, m0;
      logic [64:0] ent;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic read
      fixed_wait = 0;
      ovr_en     = 1'b1;
      ovr_data   = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = 32'h40;
      if_exp.push_back(32'hDEADBEEF);
      @(negedge clk);
      chk1("basic_bus_req_before", bus_req, 1'b0);
      @(negedge clk);
      chk1("basic_bus_req", bus_req, 1'b1);
      chk("basic_bus_addr", bus_addr, 32'h40);
      chk1("basic_stall_busy", stall, 1'b1);
      @(negedge clk);
      chk1("basic_if_ack", if_ack, 1'b1);
      chk("basic_if_rdata", if_rdata, 32'hDEADBEEF);
      chk1("basic_stall_ack", stall, 1'b0);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      @(negedge clk);
      chk1("basic_if_ack_drop", if_ack, 1'b0);
      ovr_en = 1'b0;

      // Write with wait states
      fixed_wait = 2;
      acc_log.delete();
      mem_access(1'b1, 32'h100, 32'h12345678);
      settle();
      chk("write_bus_cycles", last_bus_cycles, 3);
      chk("write_access_count", acc_log.size(), 1);
      if (acc_log.size() >= 1) begin
         ent = acc_log[0];
         chk1("write_bus_we", ent[64], 1'b1);
         chk("write_bus_addr", ent[63:32], 32'h100);
         chk("write_bus_wdata", ent[31:0], 32'h12345678);
      end

      // Contention
      fixed_wait = 0;
      contention_pair(32'h50, 32'h1004, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
      contention_pair(32'h54, 32'h1008, 1'b1);
`else
      contention_pair(32'h54, 32'h1008, 1'b0);
`endif

      // Randomised traffic on both ports
      fixed_wait = -1;
      n0 = n_acc;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [31:0] a;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               a = 32'(4 * $urandom_range(0, 15));
               if_access(a, init_val(a));
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               logic [31:0] a;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
               mem_access(1'($urandom_range(0, 1)), a, $urandom);
            end
         end
      join
      settle();
      chk("rand_access_count", n_acc - n0, 80);
      chk("rand_if_pending", if_exp.size(), 0);
      chk("rand_mem_pending", mem_exp.size(), 0);
      chk1("rand_timeout_err", timeout_err, 1'b0);

      // Early request drop
      fixed_wait = 1;
      n0 = n_acc;
      a0 = n_if_ack;
      @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = 32'h44;
      if_exp.push_back(init_val(32'h44));
      @(posedge clk);
      #1;
      if_req = 1'b0;
      for (int i = 0; i < 30 && n_if_ack == a0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      #1;
      chk("drop_ack_count", n_if_ack - a0, 1);
      chk("drop_access_count", n_acc - n0, 1);
      chk("drop_bus_cycles", last_bus_cycles, 2);

      // Timeout
      bus_hang = 1'b1;
      if_access(32'h48, 32'h0);
      settle();
      chk("timeout_bus_cycles", last_bus_cycles, 16);
      chk1("timeout_err_set", timeout_err, 1'b1);
      bus_hang   = 1'b0;
      fixed_wait = 0;
      if_access(32'h4C, init_val(32'h4C));
      settle();
      chk1("timeout_err_sticky", timeout_err, 1'b1);

      // Reset during BUSY_MEM
      bus_hang = 1'b1;
      @(posedge clk);
      #1;
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 32'h200;
      mem_wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      chk1("midrst_busy", bus_req, 1'b1);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      mem_req = 1'b0;
      m0      = n_mem_ack;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_all_zero();
      bus_hang = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("midrst_no_mem_ack", n_mem_ack - m0, 0);
      chk1("midrst_no_write", bus_mem.exists(32'h200), 1'b0);
      fixed_wait = -1;
      if_access(32'h40, init_val(32'h40));
      settle();
      chk("midrst_if_pending", if_exp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
